demux3_1_2: RTL and testbench

DEMUX3_1_2 -- requirements
Module: demux3_1_2

---
 rtl/demux3_1_2.sv | 85 ++++++++
 tb/tb_demux3_1_2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux3_1_2.sv
// 1-to-2 demultiplexer with a small circular FIFO in front of each output.
// The input is routed by cntrl to the selected buffer, and each output drains on its own.
module demux3_1_2 #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in,
  input  logic                     cntrl,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out0,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out1,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   cnt0,
  output logic [$clog2(DEPTH):0]   cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a word moves on a rising edge only when valid && ready are both high.
  // in_ready reflects only the buffer that cntrl selects, so a full idle path never blocks.
  // outk_valid is registered state (count != 0) and never depends on outk_ready.

  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_rdy;
  logic [WIDTH-1:0] head [2];
  logic [CW-1:0]    cnt  [2];

  assign out_rdy  = {out1_ready, out0_ready};
  assign in_ready = cntrl ? !full[1] : !full[0];

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    assign full[k]  = (count == CW'(DEPTH));
    assign valid[k] = (count != '0);
    assign push[k]  = in_valid && in_ready && (cntrl == 1'(k));
    assign pop[k]   = valid[k] && out_rdy[k];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst_n && push[k]) mem[wr_ptr] <= in;
    end

    // Stale buffer contents are masked so an empty output reads as zero.
    assign head[k] = valid[k] ? mem[rd_ptr] : '0;
    assign cnt[k]  = count;
  end

  assign out0       = head[0];
  assign out1       = head[1];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux3_1_2.sv
// Directed and randomised checks for demux3_1_2 with default parameters.
module tb_demux3_1_2;
  localparam int WIDTH = 3;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             cntrl;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  demux3_1_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .cntrl(cntrl), .in_valid(in_valid),
    .in_ready(in_ready), .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in         = '0;
    cntrl      = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %0h exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %0h exp 0", out1_valid); end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    checks++; if (out0 !== 3'd0) begin errors++; $display("FAIL reset_out0 got %0h exp 0", out0); end
    checks++; if (out1 !== 3'd0) begin errors++; $display("FAIL reset_out1 got %0h exp 0", out1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_push();
    in = 3'b101; cntrl = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out0 !== 3'b101) begin errors++; $display("FAIL basic_out0 got %0h exp 5", out0); end
    checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL basic_out0_valid got %0h exp 1", out0_valid); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL basic_cnt0 got %0d exp 1", cnt0); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL basic_out1_valid got %0h exp 0", out1_valid); end
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL basic_drain_cnt0 got %0d exp 0", cnt0); end
    checks++; if (out0 !== 3'd0) begin errors++; $display("FAIL basic_drain_out0 got %0h exp 0", out0); end
  endtask

  task automatic test_full_other_path();
    cntrl = 1'b1; in_valid = 1'b1; in = 3'b001;
    step();
    in = 3'b010;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (cnt1 !== 2'd2) begin errors++; $display("FAIL full1_cnt1 got %0d exp 2", cnt1); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full1_in_ready got %0h exp 0", in_ready); end
    checks++; if (out1 !== 3'b001) begin errors++; $display("FAIL full1_out1 got %0h exp 1", out1); end
    cntrl = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL other_in_ready got %0h exp 1", in_ready); end
    in = 3'b111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out0 !== 3'b111) begin errors++; $display("FAIL other_out0 got %0h exp 7", out0); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL other_cnt0 got %0d exp 1", cnt0); end
    checks++; if (cnt1 !== 2'd2) begin errors++; $display("FAIL other_cnt1 got %0d exp 2", cnt1); end
  endtask

  task automatic test_full_pop_push();
    cntrl = 1'b1; in_valid = 1'b1; in = 3'b110; out1_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready got %0h exp 0", in_ready); end
    step();
    in_valid = 1'b0; out1_ready = 1'b0;
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL fullpop_cnt1 got %0d exp 1", cnt1); end
    checks++; if (out1 !== 3'b010) begin errors++; $display("FAIL fullpop_out1 got %0h exp 2", out1); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL fullpop_cnt0 got %0d exp 1", cnt0); end
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL fullpop_drain_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL fullpop_drain_cnt1 got %0d exp 0", cnt1); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drain_out1_valid got %0h exp 0", out1_valid); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] w;
    out0_ready = 1'b1; cntrl = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w  = WIDTH'(i);
      in = w;
      step();
      checks++; if (out0 !== w) begin errors++; $display("FAIL stream_out0[%0d] got %0h exp %0h", i, out0, w); end
      checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL stream_cnt0[%0d] got %0d exp 1", i, cnt0); end
    end
    in_valid = 1'b0;
    step();
    out0_ready = 1'b0;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %0h exp 0", out0_valid); end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL stream_end_cnt0 got %0d exp 0", cnt0); end
  endtask

  task automatic test_mid_reset();
    cntrl = 1'b0; in_valid = 1'b1; in = 3'b011;
    step();
    in = 3'b100;
    step();
    cntrl = 1'b1; in = 3'b110;
    step();
    checks++; if (cnt0 !== 2'd2 || cnt1 !== 2'd1) begin errors++; $display("FAIL midrst_setup got %0d/%0d exp 2/1", cnt0, cnt1); end
    in = 3'b001;
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL midrst_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL midrst_cnt1 got %0d exp 0", cnt1); end
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids got %0h%0h exp 00", out1_valid, out0_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0h exp 1", in_ready); end
    cntrl = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready0 got %0h exp 1", in_ready); end
  endtask

  task automatic test_random();
    logic             exp_ready;
    logic             do_pop0;
    logic             do_pop1;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    exp_q0.delete();
    exp_q1.delete();
    for (int c = 0; c < 10000; c++) begin
      e0 = (exp_q0.size() != 0) ? exp_q0[0] : '0;
      e1 = (exp_q1.size() != 0) ? exp_q1[0] : '0;
      checks++; if (out0 !== e0) begin errors++; $display("FAIL rand_out0 cyc %0d got %0h exp %0h", c, out0, e0); end
      checks++; if (out1 !== e1) begin errors++; $display("FAIL rand_out1 cyc %0d got %0h exp %0h", c, out1, e1); end
      checks++; if (out0_valid !== (exp_q0.size() != 0)) begin errors++; $display("FAIL rand_out0_valid cyc %0d got %0h", c, out0_valid); end
      checks++; if (out1_valid !== (exp_q1.size() != 0)) begin errors++; $display("FAIL rand_out1_valid cyc %0d got %0h", c, out1_valid); end
      checks++; if (int'(cnt0) != exp_q0.size()) begin errors++; $display("FAIL rand_cnt0 cyc %0d got %0d exp %0d", c, cnt0, exp_q0.size()); end
      checks++; if (int'(cnt1) != exp_q1.size()) begin errors++; $display("FAIL rand_cnt1 cyc %0d got %0d exp %0d", c, cnt1, exp_q1.size()); end
      cntrl      = 1'($urandom_range(0, 1));
      in_valid   = 1'($urandom_range(0, 1));
      in         = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = cntrl ? (exp_q1.size() != DEPTH) : (exp_q0.size() != DEPTH);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready cyc %0d got %0h exp %0h", c, in_ready, exp_ready); end
      do_pop0 = out0_ready && (exp_q0.size() != 0);
      do_pop1 = out1_ready && (exp_q1.size() != 0);
      if (do_pop0) void'(exp_q0.pop_front());
      if (do_pop1) void'(exp_q1.pop_front());
      if (in_valid && exp_ready) begin
        if (cntrl) exp_q1.push_back(in);
        else       exp_q0.push_back(in);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic_push();
    test_full_other_path();
    test_full_pop_push();
    test_stream();
    test_mid_reset();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
